// File: rtl/sd_clk_pkg.sv
// Shared constants and state type for the SD bus clock divider.
// Divide counts are in 50 MHz system-clock cycles per SD-clock period.
package sd_clk_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] INIT_COUNT_DEF = 16'd125;
  localparam logic [CNT_W-1:0] MIN_COUNT_DEF  = 16'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/sd_clk_divider_if.sv
// Request/status bundle between the divide-count generator, the divider
// and the SD command/data engines.
interface sd_clk_divider_if;
  import sd_clk_pkg::*;

  logic [CNT_W-1:0] count_in;
  logic             load;
  logic             err_in;
  logic             enable;
  logic             sd_clk;
  logic             rise_stb;
  logic             fall_stb;
  logic             running;
  logic [CNT_W-1:0] cur_count;
  logic             load_ack;
  logic             load_rej;
  logic             clamped;

  modport master (
    output count_in, load, err_in, enable,
    input  sd_clk, rise_stb, fall_stb, running, cur_count,
           load_ack, load_rej, clamped
  );

  modport slave (
    input  count_in, load, err_in, enable,
    output sd_clk, rise_stb, fall_stb, running, cur_count,
           load_ack, load_rej, clamped
  );

endinterface

// File: rtl/sd_clk_divider.sv
// Glitch-free registered SD clock divider with edge strobes; divisor and
// start/stop changes only take effect on SD-clock period boundaries.
module sd_clk_divider
  import sd_clk_pkg::*;
#(
  parameter logic [CNT_W-1:0] INIT_COUNT = INIT_COUNT_DEF,
  parameter logic [CNT_W-1:0] MIN_COUNT  = MIN_COUNT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  sd_clk_divider_if.slave bus
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] ph, ph_nx;
  logic [CNT_W-1:0] cur_count, cur_nx;
  logic [CNT_W-1:0] pend, pend_nx;
  logic             pend_valid, pend_valid_nx;
  logic             sd_clk, sd_nx;
  logic             rise_stb, fall_stb, running;
  logic             load_ack, load_rej, clamped;

  logic             accept;
  logic [CNT_W-1:0] req;
  logic             wrap;
  logic [CNT_W-1:0] ph_inc;

  assign accept = bus.load & ~bus.err_in;
  assign req    = (bus.count_in < MIN_COUNT) ? MIN_COUNT : bus.count_in;
  assign wrap   = (state != IDLE) && (ph == cur_count - 16'd1);
  assign ph_inc = ph + 16'd1;

  // Next-state view; a load in the same cycle as a wrap stays pending,
  // so the divisor consumed at the wrap is always the older one.
  always_comb begin
    state_nx      = state;
    ph_nx         = ph;
    cur_nx        = cur_count;
    pend_nx       = pend;
    pend_valid_nx = pend_valid;
    sd_nx         = sd_clk;
    if (accept) begin
      pend_nx       = req;
      pend_valid_nx = 1'b1;
    end
    case (state)
      IDLE: begin
        ph_nx         = '0;
        sd_nx         = 1'b0;
        pend_valid_nx = 1'b0;
        if (accept) begin
          cur_nx = req;
        end else if (pend_valid) begin
          cur_nx = pend;
        end
        if (bus.enable) begin
          state_nx = RUN;
          sd_nx    = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          ph_nx = '0;
          if (pend_valid) begin
            cur_nx = pend;
            if (!accept) pend_valid_nx = 1'b0;
          end
          state_nx = bus.enable ? RUN : IDLE;
          sd_nx    = bus.enable;
        end else begin
          ph_nx    = ph_inc;
          sd_nx    = (ph_inc < (cur_count >> 1));
          state_nx = bus.enable ? RUN : STOPPING;
        end
      end
      default: begin
        state_nx = IDLE;
        sd_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ph         <= '0;
      cur_count  <= INIT_COUNT;
      pend       <= INIT_COUNT;
      pend_valid <= 1'b0;
      sd_clk     <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      running    <= 1'b0;
      load_ack   <= 1'b0;
      load_rej   <= 1'b0;
      clamped    <= 1'b0;
    end else begin
      state      <= state_nx;
      ph         <= ph_nx;
      cur_count  <= cur_nx;
      pend       <= pend_nx;
      pend_valid <= pend_valid_nx;
      sd_clk     <= sd_nx;
      rise_stb   <= sd_nx & ~sd_clk;
      fall_stb   <= ~sd_nx & sd_clk;
      running    <= (state_nx != IDLE);
      load_ack   <= accept;
      load_rej   <= bus.load & bus.err_in;
      if (accept) clamped <= (bus.count_in < MIN_COUNT);
    end
  end

  assign bus.sd_clk    = sd_clk;
  assign bus.rise_stb  = rise_stb;
  assign bus.fall_stb  = fall_stb;
  assign bus.running   = running;
  assign bus.cur_count = cur_count;
  assign bus.load_ack  = load_ack;
  assign bus.load_rej  = load_rej;
  assign bus.clamped   = clamped;

endmodule

// File: tb/tb_sd_clk_divider.sv
// Self-checking bench for sd_clk_divider: directed sequences, an IDLE load
// table, and randomized traffic against a timestamp-based period model.
module tb_sd_clk_divider;
  import sd_clk_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  sd_clk_divider_if bus();

  sd_clk_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a period is described by its start cycle and length, nothing more.
  logic        m_sd, m_rise, m_fall, m_active, m_ack, m_rej, m_clamped, m_pv;
  logic [15:0] m_cur, m_pend;
  int          m_cyc = 0;
  int          m_start = 0;

  typedef struct {
    logic        ld;
    logic        er;
    logic [15:0] cnt;
    logic [15:0] exp_cur;
    logic        exp_ack;
    logic        exp_rej;
    logic        exp_clamped;
  } vec_t;

  vec_t table_v[8];

  task automatic model_update(input logic rst_n, input logic en, input logic ld,
                              input logic er, input logic [15:0] cnt);
    logic        prev_sd;
    logic        acc;
    logic [15:0] req;
    m_cyc++;
    prev_sd = m_sd;
    acc = ld && !er;
    req = (cnt < MIN_COUNT_DEF) ? MIN_COUNT_DEF : cnt;
    if (!rst_n) begin
      m_active = 0; m_cur = INIT_COUNT_DEF; m_pv = 0; m_sd = 0;
      m_rise = 0; m_fall = 0; m_ack = 0; m_rej = 0; m_clamped = 0;
    end else begin
      if (!m_active) begin
        if (acc) m_cur = req;
        else if (m_pv) m_cur = m_pend;
        m_pv = 0;
        if (en) begin
          m_active = 1;
          m_start = m_cyc;
        end
      end else begin
        if (m_cyc - 1 - m_start == int'(m_cur) - 1) begin
          if (m_pv) m_cur = m_pend;
          m_pv = 0;
          if (en) m_start = m_cyc;
          else m_active = 0;
        end
        if (acc) begin
          m_pend = req;
          m_pv = 1;
        end
      end
      m_sd   = m_active && ((m_cyc - m_start) < int'(m_cur) / 2);
      m_rise = m_sd && !prev_sd;
      m_fall = !m_sd && prev_sd;
      m_ack  = acc;
      m_rej  = ld && er;
      if (acc) m_clamped = (cnt < MIN_COUNT_DEF);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [22:0] act, exp;
    act = {bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.running, bus.cur_count,
           bus.load_ack, bus.load_rej, bus.clamped};
    exp = {m_sd, m_rise, m_fall, m_active, m_cur, m_ack, m_rej, m_clamped};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, m_cyc, act, exp);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic er,
                               input logic [15:0] cnt);
    bus.enable   = en;
    bus.load     = ld;
    bus.err_in   = er;
    bus.count_in = cnt;
    @(posedge clk);
    model_update(reset, en, ld, er, cnt);
    #1;
    checkOutput("model");
  endtask

  // Called right after a rise; returns high and low lengths of that period.
  task automatic measure_period(output int hi, output int lo);
    hi = 1;
    lo = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      if (bus.sd_clk) hi++;
      else break;
    end
    lo = 1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      if (!bus.sd_clk) lo++;
      else break;
    end
  endtask

  task automatic wait_rise(output int steps);
    steps = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      steps++;
      if (bus.rise_stb) break;
    end
  endtask

  initial begin
    int hi, lo, steps, rises, fall_at, run_lo;

    bus.enable = 0; bus.load = 0; bus.err_in = 0; bus.count_in = 0;

    reset = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    expect_eq("reset_sd_clk", 32'(bus.sd_clk), 32'd0);
    expect_eq("reset_cur_count", 32'(bus.cur_count), 32'd125);
    expect_eq("reset_running", 32'(bus.running), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
    expect_eq("first_rise_stb", 32'(bus.rise_stb), 32'd1);
    expect_eq("first_sd_clk", 32'(bus.sd_clk), 32'd1);
    measure_period(hi, lo);
    expect_eq("n125_high", 32'(hi), 32'd62);
    expect_eq("n125_low", 32'(lo), 32'd63);

    repeat (19) applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd2);
    expect_eq("midperiod_ack", 32'(bus.load_ack), 32'd1);
    expect_eq("midperiod_cur_held", 32'(bus.cur_count), 32'd125);
    wait_rise(steps);
    expect_eq("n125_completes", 32'(steps), 32'd105);
    expect_eq("cur_after_wrap", 32'(bus.cur_count), 32'd2);
    measure_period(hi, lo);
    expect_eq("n2_high", 32'(hi), 32'd1);
    expect_eq("n2_low", 32'(lo), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3);
    wait_rise(steps);
    expect_eq("n3_cur", 32'(bus.cur_count), 32'd3);
    measure_period(hi, lo);
    expect_eq("n3_high", 32'(hi), 32'd1);
    expect_eq("n3_low", 32'(lo), 32'd2);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'd10);
    wait_rise(steps);
    wait_rise(steps);
    expect_eq("n10_cur", 32'(bus.cur_count), 32'd10);

    // Stop requested during the high phase: the period must run to completion.
    rises = 0; fall_at = -1;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(i <= 2, 1'b0, 1'b0, 16'd0);
      if (bus.rise_stb) rises++;
      if (bus.fall_stb) fall_at = i;
      if (i == 9) expect_eq("stop_running_before_wrap", 32'(bus.running), 32'd1);
      if (i == 10) expect_eq("stop_running_after_wrap", 32'(bus.running), 32'd0);
    end
    expect_eq("stop_fall_pos", 32'(fall_at), 32'd5);
    expect_eq("stop_no_rise", 32'(rises), 32'd0);
    expect_eq("stop_parked", 32'(bus.sd_clk), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
    expect_eq("restart_rise", 32'(bus.rise_stb), 32'd1);
    rises = 0; fall_at = -1; run_lo = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus((i <= 2) || (i >= 7), 1'b0, 1'b0, 16'd0);
      if (bus.rise_stb && i < 10) rises++;
      if (bus.fall_stb) fall_at = i;
      if (!bus.running) run_lo++;
      if (i == 10) expect_eq("reenable_rise_at_10", 32'(bus.rise_stb), 32'd1);
    end
    expect_eq("reenable_no_early_rise", 32'(rises), 32'd0);
    expect_eq("reenable_fall_pos", 32'(fall_at), 32'd5);
    expect_eq("reenable_kept_running", 32'(run_lo), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'd50);
    expect_eq("pre_reset_ack", 32'(bus.load_ack), 32'd1);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
    expect_eq("midreset_sd_clk", 32'(bus.sd_clk), 32'd0);
    expect_eq("midreset_no_fall", 32'(bus.fall_stb), 32'd0);
    expect_eq("midreset_cur", 32'(bus.cur_count), 32'd125);
    reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    expect_eq("pending_discarded", 32'(bus.cur_count), 32'd125);

    table_v[0] = '{1'b1, 1'b0, 16'd1,     16'd2,     1'b1, 1'b0, 1'b1};
    table_v[1] = '{1'b1, 1'b0, 16'd0,     16'd2,     1'b1, 1'b0, 1'b1};
    table_v[2] = '{1'b1, 1'b1, 16'd50,    16'd2,     1'b0, 1'b1, 1'b1};
    table_v[3] = '{1'b1, 1'b0, 16'd3,     16'd3,     1'b1, 1'b0, 1'b0};
    table_v[4] = '{1'b0, 1'b0, 16'd77,    16'd3,     1'b0, 1'b0, 1'b0};
    table_v[5] = '{1'b1, 1'b1, 16'd9,     16'd3,     1'b0, 1'b1, 1'b0};
    table_v[6] = '{1'b1, 1'b0, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 1'b0};
    table_v[7] = '{1'b1, 1'b0, 16'd2,     16'd2,     1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, table_v[i].ld, table_v[i].er, table_v[i].cnt);
      expect_eq($sformatf("idle_table_%0d", i),
                32'({bus.cur_count, bus.load_ack, bus.load_rej, bus.clamped}),
                32'({table_v[i].exp_cur, table_v[i].exp_ack, table_v[i].exp_rej,
                     table_v[i].exp_clamped}));
    end

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      applyStimulus($urandom_range(0, 99) < 85, ($urandom % 8) == 0,
                    ($urandom % 4) == 0, 16'($urandom_range(0, 11)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_clk_divider.md
# sd_clk_divider

Consumes the 16-bit divide count produced from the card's TRAN_SPEED field (50 MHz / rate) and generates the SD bus clock from the 50 MHz system clock. It is a registered, glitch-free divider with edge strobes for the command/data engines. Divisor changes and start/stop are applied only at SD-clock period boundaries. It sits between the clock-divide-count generator and the SD command/data path.

## Interface
- INIT_COUNT, 125: divisor after reset (400 kHz identification clock from 50 MHz).
- MIN_COUNT, 2: smallest legal divisor; smaller requests are clamped.
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- count_in  in  16  requested divisor, in clk cycles per SD-clock period.
- load  in  1  one-cycle pulse; count_in valid (driven from the generator's ok).
- err_in  in  1  generator error; a load with err_in=1 is rejected.
- enable  in  1  level; 1 = run SD clock, 0 = park low.
- sd_clk  out  1  registered SD bus clock.
- rise_stb  out  1  high in the cycle sd_clk goes 0→1.
- fall_stb  out  1  high in the cycle sd_clk goes 1→0.
- running  out  1  clock is toggling (state RUN or STOPPING).
- cur_count  out  16  divisor currently in effect.
- load_ack  out  1  one-cycle pulse: request accepted into pending register.
- load_rej  out  1  one-cycle pulse: request rejected (err_in).
- clamped  out  1  sticky: last accepted request was < MIN_COUNT; cleared by next accepted load ≥ MIN_COUNT.

## Operation
- States: IDLE (sd_clk=0, phase held at 0), RUN, STOPPING (finishing current period).
- IDLE→RUN when enable=1; RUN→STOPPING when enable=0; STOPPING→IDLE at period end; STOPPING→RUN if enable returns to 1 before period end (no extra edge, no truncation).
- Phase counter ph runs 0..N-1, N = cur_count; wraps to 0 at N-1 (period end). High time H = floor(N/2); sd_clk = (ph < H). Odd N: low phase one cycle longer.
- Load handling: load=1, err_in=0 → pending ← max(count_in, MIN_COUNT), pending_valid=1, load_ack next cycle. load=1, err_in=1 → pending unchanged, load_rej next cycle.
- Pending applied: in IDLE, next cycle; in RUN/STOPPING, at period end (ph=N-1→0) so new divisor governs the following full period. Second load before apply: last wins, one ack per load.
- Compares in 16-bit unsigned; cur_count never < MIN_COUNT.
- Reset mid-operation: sd_clk forced 0 immediately at next edge; pending discarded; no strobe generated.

## Timing
- Reset values: sd_clk 0, rise_stb 0, fall_stb 0, running 0, cur_count INIT_COUNT, load_ack 0, load_rej 0, clamped 0; state IDLE, ph 0.
- enable sampled 1 in IDLE at cycle t → sd_clk=1 and rise_stb=1 at t+1.
- Steady state: rise_stb every N cycles; fall_stb H cycles after rise_stb.
- enable sampled 0 at cycle t in RUN → sd_clk completes period; last falling edge kept, running drops the cycle after the wrap; no partial high pulse ever.
- load at t → load_ack at t+1; cur_count updates at t+1 (IDLE) or in the wrap cycle (RUN).
- Load and period end in same cycle: load applies at the next period end, not this one.

## Structure
- Shared package sd_clk_pkg: MIN_COUNT, INIT_COUNT defaults, state enum (IDLE/RUN/STOPPING), count width constant 16.
- Single module; no sub-module — phase counter, pending register and FSM are tightly coupled.

## Test plan
- Reset, enable=1, no load → sd_clk period 125 clks, high 62, low 63; first rise_stb 1 cycle after enable.
- In RUN with N=125, load count_in=2 mid-period → current period completes at 125, then period 2 (1 high/1 low); load_ack 1 cycle after load.
- load count_in=1 and count_in=0 → cur_count=2, clamped=1; subsequent load 3 → clamped=0, high 1/low 2.
- load with err_in=1 → load_rej pulse, cur_count unchanged, no ack.
- Deassert enable in high phase (N=10) → high and low phases complete, sd_clk parks 0, running=0; re-enable within low phase of STOPPING → no glitch, period exactly 10.
- Reset asserted while sd_clk=1 → sd_clk=0 next edge, cur_count=125, pending lost, no fall_stb.
